if_id_skid_latch: RTL and testbench

- Fetch-to-decode pipeline stage for the 16-bit processor.
- Takes instruction and PC+2 words from fetch over a valid/ready handshake and presents them to decode.
- Two-entry skid buffer so that `in_ready` is a pure register output and never depends combinationally on `out_ready`.
- Supports flush (branch/jump redirect) and a sticky halt that stops accepting fetches once a HALT instruction has been taken.

---
 rtl/if_id_skid_latch_if.sv | 32 +++
 rtl/if_id_skid_latch.sv | 128 ++++++++++++
 tb/tb_if_id_skid_latch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_latch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_id_skid_latch_if                                           |
// | Brief    : Fetch/decode handshake bundle for the IF/ID skid stage.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface if_id_skid_latch_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc_next;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc_next;
  logic              flush;
  logic              halted;

  // Master is the surrounding pipeline (fetch, decode, redirect control).
  modport master (
    output in_valid, in_instr, in_pc_next, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc_next, halted
  );

  modport slave (
    input  in_valid, in_instr, in_pc_next, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc_next, halted
  );
endinterface
`default_nettype wire

// File: rtl/if_id_skid_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_id_skid_latch                                              |
// | Brief    : Two-entry IF/ID skid stage with flush and sticky halt.        |
// |            Define IFID_FLUSH_NOP_EN to insert a NOP bubble on flush.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module if_id_skid_latch #(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] HALT_INSTR = 16'h0000,
  parameter logic [DATA_W-1:0] NOP_INSTR  = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  if_id_skid_latch_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [DATA_W-1:0] r_mainInstr;
  logic [DATA_W-1:0] r_mainPc;
  logic [DATA_W-1:0] r_skidInstr;
  logic [DATA_W-1:0] r_skidPc;
  logic [DATA_W-1:0] w_mainInstrNext;
  logic [DATA_W-1:0] w_mainPcNext;
  logic [DATA_W-1:0] w_skidInstrNext;
  logic [DATA_W-1:0] w_skidPcNext;
  logic              r_halted;
  logic              w_haltedNext;
  logic              w_inReady;
  logic              w_outValid;
  logic              w_push;
  logic              w_pop;

  // Ready depends only on held state, so fetch never sees out_ready ripple.
  assign w_inReady  = (r_state != TWO) && !r_halted && !rst;
  assign w_outValid = (r_state != EMPTY);
  assign w_push     = bus.in_valid && w_inReady;
  assign w_pop      = w_outValid && bus.out_ready;

  assign bus.in_ready    = w_inReady;
  assign bus.out_valid   = w_outValid;
  assign bus.out_instr   = r_mainInstr;
  assign bus.out_pc_next = r_mainPc;
  assign bus.halted      = r_halted;

  always_comb begin
    w_stateNext     = r_state;
    w_mainInstrNext = r_mainInstr;
    w_mainPcNext    = r_mainPc;
    w_skidInstrNext = r_skidInstr;
    w_skidPcNext    = r_skidPc;
    w_haltedNext    = r_halted;

    if (bus.flush) begin
`ifdef IFID_FLUSH_NOP_EN
      w_stateNext     = ONE;
      w_mainInstrNext = NOP_INSTR;
      w_mainPcNext    = {DATA_W{1'b0}};
`else
      w_stateNext     = EMPTY;
`endif
    end else begin
      if (w_push && (bus.in_instr == HALT_INSTR)) begin
        w_haltedNext = 1'b1;
      end

      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_stateNext     = ONE;
            w_mainInstrNext = bus.in_instr;
            w_mainPcNext    = bus.in_pc_next;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_mainInstrNext = bus.in_instr;
            w_mainPcNext    = bus.in_pc_next;
          end else if (w_push) begin
            w_stateNext     = TWO;
            w_skidInstrNext = bus.in_instr;
            w_skidPcNext    = bus.in_pc_next;
          end else if (w_pop) begin
            w_stateNext     = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the stage.
          if (w_pop) begin
            w_stateNext     = ONE;
            w_mainInstrNext = r_skidInstr;
            w_mainPcNext    = r_skidPc;
          end
        end
        default: begin
          w_stateNext = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_mainInstr <= {DATA_W{1'b0}};
      r_mainPc    <= {DATA_W{1'b0}};
      r_skidInstr <= {DATA_W{1'b0}};
      r_skidPc    <= {DATA_W{1'b0}};
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_mainInstr <= w_mainInstrNext;
      r_mainPc    <= w_mainPcNext;
      r_skidInstr <= w_skidInstrNext;
      r_skidPc    <= w_skidPcNext;
      r_halted    <= w_haltedNext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_if_id_skid_latch                                           |
// | Brief    : Scoreboard bench for the IF/ID skid stage.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_if_id_skid_latch;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_skid_latch_if #(.DATA_W(DATA_W)) bus ();

  if_id_skid_latch #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sbQ[$];
  bit          sbOn = 1'b0;

  // Scoreboard: words enter on accepted pushes and leave on pops.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (sbOn && !rst) begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got %h/%h with empty queue", bus.out_instr, bus.out_pc_next);
        end else begin
          exp = sbQ.pop_front();
          if ({bus.out_instr, bus.out_pc_next} !== exp) begin
            errors++;
            $display("FAIL sb_order got %h/%h want %h/%h", bus.out_instr, bus.out_pc_next, exp[31:16], exp[15:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready && !bus.flush)
        sbQ.push_back({bus.in_instr, bus.in_pc_next});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_pc_next = '0;
    bus.out_ready  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", bus.halted); end
    checks++; if ({bus.out_instr, bus.out_pc_next} !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h/%h want 0/0", bus.out_instr, bus.out_pc_next); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_streaming();
    logic [15:0] instr;
    sbQ.delete();
    sbOn = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr          = 16'h4123 + 16'(i);
      bus.in_valid   = 1'b1;
      bus.in_instr   = instr;
      bus.in_pc_next = 16'h0002 + 16'(2 * i);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== instr || bus.out_pc_next !== 16'h0002 + 16'(2 * i)) begin
        errors++;
        $display("FAIL stream_word%0d got v=%b %h/%h want v=1 %h/%h", i, bus.out_valid, bus.out_instr, bus.out_pc_next, instr, 16'h0002 + 16'(2 * i));
      end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b want 1", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got v=%b want 0", bus.out_valid); end
    checks++; if (sbQ.size() != 0) begin errors++; $display("FAIL stream_leftover got %0d words want 0", sbQ.size()); end
  endtask

  task automatic test_skid();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_instr   = 16'hA001;
    bus.in_pc_next = 16'h0100;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_one got %b want 1", bus.in_ready); end
    bus.in_instr   = 16'hA002;
    bus.in_pc_next = 16'h0102;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_two got %b want 0", bus.in_ready); end
    checks++; if (bus.out_instr !== 16'hA001) begin errors++; $display("FAIL skid_head got %h want a001", bus.out_instr); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_instr !== 16'hA002 || bus.out_pc_next !== 16'h0102) begin errors++; $display("FAIL skid_second got %h/%h want a002/0102", bus.out_instr, bus.out_pc_next); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_after_pop got %b want 1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got v=%b want 0", bus.out_valid); end
    sbOn = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_instr   = 16'hC001;
    bus.in_pc_next = 16'h0200;
    tick();
    bus.in_instr   = 16'hC002;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup_two got ready=%b want 0", bus.in_ready); end
    bus.flush      = 1'b1;
    bus.in_instr   = 16'hB000;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
`ifdef IFID_FLUSH_NOP_EN
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h0800 || bus.out_pc_next !== 16'h0000) begin errors++; $display("FAIL flush_nop got v=%b %h/%h want v=1 0800/0000", bus.out_valid, bus.out_instr, bus.out_pc_next); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_nop_drain got v=%b want 0", bus.out_valid); end
`else
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got v=%b want 0", bus.out_valid); end
`endif
    checks++; if (bus.out_instr === 16'hB000) begin errors++; $display("FAIL flush_dropped got %h want not b000", bus.out_instr); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_halt();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_instr   = 16'h0000;
    bus.in_pc_next = 16'h0010;
    tick();
    bus.in_instr = 16'h5555;
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b want 1", bus.halted); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got %b want 0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h0000 || bus.out_pc_next !== 16'h0010) begin errors++; $display("FAIL halt_word got v=%b %h/%h want v=1 0000/0010", bus.out_valid, bus.out_instr, bus.out_pc_next); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_no_accept got v=%b %h want empty", bus.out_valid, bus.out_instr); end
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_survives_flush got %b want 1", bus.halted); end
    rst = 1'b1;
    #1;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_cleared_by_rst got %b want 0", bus.halted); end
    tick();
    rst = 1'b0;
    idleInputs();
  endtask

  task automatic test_async_reset();
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_instr   = 16'hD001;
    bus.in_pc_next = 16'h0300;
    tick();
    bus.in_instr   = 16'h0000;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.halted !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL arst_setup got v=%b h=%b r=%b want 1/1/0", bus.out_valid, bus.halted, bus.in_ready); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0 || bus.out_instr !== 16'h0000) begin errors++; $display("FAIL arst_immediate got v=%b h=%b i=%h want 0/0/0000", bus.out_valid, bus.halted, bus.out_instr); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_release got r=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_random();
    logic     readyBefore;
    int       seq = 0;
    sbQ.delete();
    sbOn = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_instr   = 16'($urandom_range(1, 16'hFFFF));
      bus.in_pc_next = 16'(seq);
      bus.out_ready  = 1'($urandom_range(0, 1));
      if (c % 10 == 0) begin
        readyBefore   = bus.in_ready;
        bus.out_ready = ~bus.out_ready;
        #1;
        checks++; if (bus.in_ready !== readyBefore) begin errors++; $display("FAIL rand_ready_comb cycle %0d got %b want %b", c, bus.in_ready, readyBefore); end
        bus.out_ready = ~bus.out_ready;
      end
      if (bus.in_valid && bus.in_ready) seq++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int d = 0; d < 4; d++) tick();
    checks++; if (sbQ.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d words want 0", sbQ.size()); end
    checks++; if (seq < 100) begin errors++; $display("FAIL rand_throughput got %0d accepted want >= 100", seq); end
    sbOn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
